// File: rtl/ram_dump_pkg.sv
// Shared types and helpers for the RAM dump transmitter.
// States, ASCII line-end constants and nibble-to-hex conversion.
package ram_dump_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        SEND,
        GUARD,
        WAITTX,
        FINISH
    } state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    function automatic logic [7:0] nib2ascii(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return 8'h37 + {4'h0, n};
    endfunction

endpackage

// File: rtl/hex2ascii.sv
// Combinational nibble to uppercase ASCII hex digit.
// Used only by the hex output mode of ram_dump_tx.
module hex2ascii
    import ram_dump_pkg::*;
(
    input  logic [3:0] nib,
    output logic [7:0] chr
);

    assign chr = nib2ascii(nib);

endmodule

// File: rtl/ram_dump_tx.sv
// Dumps LEN bytes of a synchronous RAM to a serial transmitter.
// Define RAM_DUMP_HEX_ASCII_EN to send bytes as ASCII hex plus CR/LF.
module ram_dump_tx
    import ram_dump_pkg::*;
#(
    parameter int AW  = 4,
    parameter int LEN = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          go,
    output logic [AW-1:0] ram_addr,
    input  logic [7:0]    ram_data,
    output logic          tx_start,
    output logic [7:0]    tx_data,
    input  logic          tx_ready,
    output logic          busy,
    output logic          done
);

    localparam logic [AW:0] LAST = (AW+1)'(LEN - 1);

    state_t      state, state_n;
    logic [AW:0] cnt, cnt_n;
    logic [7:0]  byte_q, byte_n;
    logic        last_byte;

    assign last_byte = (cnt == LAST);

`ifdef RAM_DUMP_HEX_ASCII_EN
    // ph: 0 high nibble, 1 low nibble, 2 CR, 3 LF
    logic [1:0] ph, ph_n;
    logic [3:0] nib;
    logic [7:0] hex_chr;
    logic [7:0] chr;

    assign nib = ph[0] ? byte_q[3:0] : byte_q[7:4];

    hex2ascii u_hex2ascii (
        .nib (nib),
        .chr (hex_chr)
    );

    assign chr = ph[1] ? (ph[0] ? ASCII_LF : ASCII_CR) : hex_chr;
    assign tx_data = (rstn && state == SEND) ? chr : 8'h00;
`else
    assign tx_data = rstn ? byte_q : 8'h00;
`endif

    assign ram_addr = rstn ? cnt[AW-1:0] : '0;
    assign tx_start = rstn && (state == SEND) && tx_ready;
    assign busy     = rstn && (state != IDLE);
    assign done     = rstn && (state == FINISH);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= IDLE;
            cnt    <= '0;
            byte_q <= 8'h00;
`ifdef RAM_DUMP_HEX_ASCII_EN
            ph     <= 2'd0;
`endif
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            byte_q <= byte_n;
`ifdef RAM_DUMP_HEX_ASCII_EN
            ph     <= ph_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        byte_n  = byte_q;
`ifdef RAM_DUMP_HEX_ASCII_EN
        ph_n    = ph;
`endif
        unique case (state)
            IDLE: begin
                if (go) begin
                    state_n = READ;
                    cnt_n   = '0;
                end
            end
            READ: state_n = LATCH;
            LATCH: begin
                byte_n  = ram_data;
                state_n = SEND;
`ifdef RAM_DUMP_HEX_ASCII_EN
                ph_n    = 2'd0;
`endif
            end
            SEND: begin
                if (tx_ready) state_n = GUARD;
            end
            // tx_ready still shows the pre-accept value here
            GUARD: state_n = WAITTX;
            WAITTX: begin
                if (tx_ready) begin
`ifdef RAM_DUMP_HEX_ASCII_EN
                    unique case (ph)
                        2'd0: begin
                            ph_n    = 2'd1;
                            state_n = SEND;
                        end
                        2'd1: begin
                            if (last_byte) begin
                                ph_n    = 2'd2;
                                state_n = SEND;
                            end else begin
                                cnt_n   = cnt + (AW+1)'(1);
                                state_n = READ;
                            end
                        end
                        2'd2: begin
                            ph_n    = 2'd3;
                            state_n = SEND;
                        end
                        2'd3: state_n = FINISH;
                    endcase
`else
                    if (last_byte) begin
                        state_n = FINISH;
                    end else begin
                        cnt_n   = cnt + (AW+1)'(1);
                        state_n = READ;
                    end
`endif
                end
            end
            FINISH: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

endmodule
